ao_wkup_ctrl: RTL
=================

Name: ao_wkup_ctrl

Overview:
- Always-on wakeup sequencer sitting next to the always-on peripheral cluster (RTC, watchdog, timer).
- Captures rising edges of the cluster's interrupt lines (rtcintr, tmrintr, wdtintr, plus spares) into sticky pending bits, masked by per-source enables.
- When software has armed sleep, sequences a four-phase wake request/acknowledge handshake with the power controller after a programmable hold-off.
- APB3 slave with zero wait states, clocked on pclk.

Parameters:
- NSRC, 4, number of wake sources (bit0 rtc, bit1 tmr, bit2 wdt, bit3 spare); 1..16.
- SYNC, 2, synchronizer flop stages on src_i (0 = sources already pclk-synchronous).
- PAW, 12, APB address width.

Ports:
- pclk  in  1  clock; the block's single clock.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write.
- paddr  in  PAW  APB byte address; bits [4:2] decoded.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  tied 1.
- pslverr  out  1  error on unmapped address.
- src_i  in  NSRC  level wake sources.
- pwr_ack_i  in  1  power controller acknowledge.
- pwr_req_o  out  1  wake request to power controller.
- sleep_o  out  1  sleep armed indication to power controller.
- irq_o  out  1  level interrupt, |(PEND & EN).

Behaviour:
- Reset values: all outputs 0 (pready=1); registers 0; FSM IDLE.
- Registers (offset, access):
  - 0x00 CTRL: bit0 SLEEP (RW; reads 1 in ARMED/HOLD).
  - 0x04 EN [NSRC-1:0] RW.
  - 0x08 PEND [NSRC-1:0] W1C.
  - 0x0C STATUS RO: [2:0] FSM state code, [8+:NSRC] synchronized src levels.
  - 0x10 HOLDOFF [15:0] RW.
  - Other offsets: pslverr=1 in the access phase; prdata=0; writes are dropped.
- APB protocol:
  - Write takes effect on the psel&penable&pwrite cycle.
  - prdata is valid in the access phase (combinational decode of registered state).
- Sources:
  - SYNC flops, then a registered edge detector; PEND[i] sets on a 0->1 transition of the synchronized src.
  - Latency: src rises at cycle N -> PEND visible at N+SYNC+1.
  - PEND sets regardless of EN.
  - If a set and a W1C of the same bit occur in one cycle, the set wins.
- irq_o is registered from PEND&EN, one cycle after the PEND update.
- FSM state codes: IDLE=0, ARMED=1, HOLD=2, REQ=3, RELEASE=4.
  - IDLE: writing CTRL.SLEEP=1 -> ARMED.
  - ARMED: sleep_o=1. Writing SLEEP=0 -> IDLE (cancel). |(PEND&EN) -> HOLD and load cnt=HOLDOFF. If pending is already set at arm time, HOLD is entered the following cycle.
  - HOLD: sleep_o=1; cnt decrements each cycle; at cnt==0 -> REQ. HOLDOFF=0 gives exactly one HOLD cycle. SLEEP writes are ignored. PEND clearing during HOLD does not abort.
  - REQ: pwr_req_o=1, sleep_o=0; stays until pwr_ack_i=1 -> RELEASE.
  - RELEASE: pwr_req_o=0; waits for pwr_ack_i=0 -> IDLE.
  - SLEEP writes are ignored in REQ and RELEASE.
  - pwr_ack_i high while in IDLE/ARMED/HOLD is ignored.
- pwr_req_o and sleep_o are registered outputs (state-decoded flops) and are glitch-free.
- Counter: 16-bit down-counter; no wrap (it stops at 0).
- Reset mid-handshake forces IDLE and pwr_req_o=0 immediately (asynchronous). The power controller must tolerate the dropped request.

Test Plan:
- Reset then read all offsets -> 0x00..0x10 read 0; read of 0x14 -> pslverr=1, prdata=0; pready=1 throughout.
- SYNC=2, EN=0x1, pulse src_i[0] at cycle 10 -> PEND=0x1 at cycle 13, irq_o=1 at 14; W1C 0x1 -> PEND=0, irq_o=0 the next cycle.
- Arm SLEEP=1, HOLDOFF=5, then raise src_i[1] with EN=0x2 -> sleep_o drops as state enters REQ exactly 6 cycles after HOLD entry; pwr_req_o=1 until ack; ack high then low -> IDLE, STATUS[2:0]=0.
- Same-cycle PEND set on bit2 and W1C of bit2 -> PEND[2]=1.
- Arm then write SLEEP=0 before any event -> IDLE, sleep_o=0, pwr_req_o never asserted; arm with PEND&EN already nonzero, HOLDOFF=0 -> ARMED 1 cycle, HOLD 1 cycle, then REQ.
- Assert presetn low while in REQ -> pwr_req_o=0 asynchronously, all registers 0 after release.

Source files
------------

// File: rtl/ao_wkup_ctrl_if.sv
// APB3 bus bundle for the always-on wakeup controller.
interface ao_wkup_ctrl_if #(
  parameter int unsigned PAW = 12
);
  logic           psel;
  logic           penable;
  logic           pwrite;
  logic [PAW-1:0] paddr;
  logic [31:0]    pwdata;
  logic [31:0]    prdata;
  logic           pready;
  logic           pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ao_wkup_ctrl.sv
// Always-on wakeup sequencer: captures wake-source edges into sticky pending
// bits and runs a four-phase request/acknowledge with the power controller.
module ao_wkup_ctrl #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned SYNC = 2,
  parameter int unsigned PAW  = 12
) (
  input  logic            pclk,
  input  logic            presetn,
  ao_wkup_ctrl_if.slave   apb,
  input  logic [NSRC-1:0] src_i,
  input  logic            pwr_ack_i,
  output logic            pwr_req_o,
  output logic            sleep_o,
  output logic            irq_o
);

  localparam int unsigned HW = 16;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_EN     = 3'd1;
  localparam logic [2:0] A_PEND   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   holdoff_q;
  logic [NSRC-1:0] en_q, pend_q, src_prev_q;
  logic [NSRC-1:0] src_sync, rise_c, w1c_c;
  logic [PAW-1:0]  addr_c;
  logic [2:0]      idx_c;
  logic            access_c, wr_c, mapped_c, wr_ctrl_c;
  logic [31:0]     rdata_c;
  logic            unused_ok;

  // APB decode; only address bits [4:2] select a register
  assign addr_c    = apb.paddr;
  assign idx_c     = addr_c[4:2];
  assign access_c  = apb.psel & apb.penable;
  assign wr_c      = access_c & apb.pwrite;
  assign mapped_c  = (idx_c <= A_HOLD);
  assign wr_ctrl_c = wr_c && (idx_c == A_CTRL);
  assign unused_ok = ^{addr_c, apb.pwdata};

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access_c & ~mapped_c;
  assign apb.prdata  = rdata_c;

  // Source synchronizer chain (bypassed when sources are already pclk-domain)
  if (SYNC == 0) begin : g_nosync
    assign src_sync = src_i;
  end else begin : g_sync
    logic [NSRC-1:0] sync_q [SYNC];
    // Shift src_i through SYNC flops
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        for (int k = 0; k < int'(SYNC); k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= src_i;
        for (int k = 1; k < int'(SYNC); k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign src_sync = sync_q[SYNC-1];
  end

  // Rising edges set pending bits; a same-cycle set beats the W1C clear
  assign rise_c = src_sync & ~src_prev_q;
  assign w1c_c  = (wr_c && (idx_c == A_PEND)) ? apb.pwdata[NSRC-1:0] : '0;

  // Read mux over registered state
  always_comb begin
    rdata_c = '0;
    case (idx_c)
      A_CTRL:   rdata_c[0] = sleep_o;
      A_EN:     rdata_c[NSRC-1:0] = en_q;
      A_PEND:   rdata_c[NSRC-1:0] = pend_q;
      A_STATUS: begin
        rdata_c[2:0]      = state_q;
        rdata_c[8 +: NSRC] = src_sync;
      end
      A_HOLD:   rdata_c[HW-1:0] = holdoff_q;
      default:  rdata_c = '0;
    endcase
  end

  // Configuration, pending capture, edge history and interrupt
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en_q       <= '0;
      holdoff_q  <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (wr_c && (idx_c == A_EN))   en_q      <= apb.pwdata[NSRC-1:0];
      if (wr_c && (idx_c == A_HOLD)) holdoff_q <= apb.pwdata[HW-1:0];
      pend_q     <= (pend_q & ~w1c_c) | rise_c;
      src_prev_q <= src_sync;
      irq_o      <= |(pend_q & en_q);
    end
  end

  // Next-state and hold-off counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl_c && apb.pwdata[0]) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (wr_ctrl_c && !apb.pwdata[0]) begin
          state_d = ST_IDLE;
        end else if (|(pend_q & en_q)) begin
          state_d = ST_HOLD;
          cnt_d   = holdoff_q;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_REQ;
        else             cnt_d   = cnt_q - HW'(1);
      end
      ST_REQ: begin
        if (pwr_ack_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!pwr_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with state-decoded output flops
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sleep_o   <= 1'b0;
      pwr_req_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sleep_o   <= (state_d == ST_ARMED) || (state_d == ST_HOLD);
      pwr_req_o <= (state_d == ST_REQ);
    end
  end

endmodule
